snn_inference_sequencer: RTL and testbench

Controller that sequences one inference window of the 4-input / 2-output spiking network. On a `start` request it latches the sensor and material vectors, holds the network in reset for one cycle, then enables it for a fixed number of timesteps. During the window it counts output spikes per excitatory neuron, including a drain period for in-flight spikes. It then reports the counts and a Left/Right decision with a one-cycle `done` pulse. It sits between the robot control logic and the network instance, and owns the network's `rst`/`en` lines.

---
 rtl/snn_inference_sequencer_if.sv | 43 ++++
 rtl/snn_inference_sequencer.sv | 163 ++++++++++++++++
 tb/tb_snn_inference_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_inference_sequencer_if.sv
// -----------------------------------------------------------------------------
// snn_inference_sequencer_if
// Bundles the control and data signals of the inference sequencer.
//   master : robot control side. It drives en, start, sensor_in and material_in.
//            It also supplies spike_in, the excitatory spikes of the network.
//            It observes the network controls and the results.
//   slave  : the sequencer itself.
// Signals:
//   en, start, sensor_in[3:0], material_in[3:0], spike_in[EXCNUM-1:0]
//   snn_rst, snn_en, snn_sensor[3:0], snn_material[3:0]
//   busy, done, count_l/count_r[CNT_W-1:0], winner[1:0]
// -----------------------------------------------------------------------------
interface snn_inference_sequencer_if #(
    parameter int EXCNUM = 2,
    parameter int CNT_W  = 5
);
    logic              en;
    logic              start;
    logic [3:0]        sensor_in;
    logic [3:0]        material_in;
    logic [EXCNUM-1:0] spike_in;
    logic              snn_rst;
    logic              snn_en;
    logic [3:0]        snn_sensor;
    logic [3:0]        snn_material;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count_l;
    logic [CNT_W-1:0]  count_r;
    logic [1:0]        winner;

    modport master (
        output en, start, sensor_in, material_in, spike_in,
        input  snn_rst, snn_en, snn_sensor, snn_material,
        input  busy, done, count_l, count_r, winner
    );

    modport slave (
        input  en, start, sensor_in, material_in, spike_in,
        output snn_rst, snn_en, snn_sensor, snn_material,
        output busy, done, count_l, count_r, winner
    );
endinterface

// File: rtl/snn_inference_sequencer.sv
// -----------------------------------------------------------------------------
// snn_inference_sequencer
// Runs one inference window of the 4-input / 2-output spiking network.
// The window proceeds as follows:
//   1. Latch the inputs.
//   2. Hold the network in reset for one cycle.
//   3. Enable the network for T_STEPS cycles.
//   4. Keep counting spikes for SETTLE drain cycles.
//   5. Publish the counts and a Left/Right decision with a one-cycle done.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; it also forces the network reset
//   bus  slave modport of snn_inference_sequencer_if (see that file)
// -----------------------------------------------------------------------------
module snn_inference_sequencer #(
    parameter int EXCNUM  = 2,
    parameter int T_STEPS = 16,
    parameter int SETTLE  = 2,
    parameter int CNT_W   = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    snn_inference_sequencer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_e;
    typedef logic [CNT_W-1:0] cnt_t;

    // A single step counter serves both the RUN and DRAIN phases.
    localparam int MAX_STEP = (T_STEPS > SETTLE) ? T_STEPS : SETTLE;
    localparam int STEP_W   = $clog2(MAX_STEP) + 1;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    cnt_t [EXCNUM-1:0]   work_q, work_d;
    cnt_t                count_l_q, count_l_d;
    cnt_t                count_r_q, count_r_d;
    logic [1:0]          winner_q, winner_d;
    logic [3:0]          sensor_q, sensor_d;
    logic [3:0]          material_q, material_d;
    logic                count_en;
    logic                load_results;

    // 00 means no spikes. 11 means a nonzero tie. Otherwise the larger count
    // wins: 01 for Left and 10 for Right.
    function automatic logic [1:0] decide(input cnt_t l, input cnt_t r);
        if (l == '0 && r == '0) return 2'b00;
        if (l == r)             return 2'b11;
        if (l > r)              return 2'b01;
        return 2'b10;
    endfunction

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this
        // block can infer a latch. Blocking assignments are correct here
        // because later lines read the values set earlier.
        state_d      = state_q;
        step_d       = step_q;
        work_d       = work_q;
        count_l_d    = count_l_q;
        count_r_d    = count_r_q;
        winner_d     = winner_q;
        sensor_d     = sensor_q;
        material_d   = material_q;
        count_en     = 1'b0;
        load_results = 1'b0;

        // With en low everything keeps its hold value: the FSM, the step
        // counter and the spike counters freeze.
        if (bus.en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        sensor_d   = bus.sensor_in;
                        material_d = bus.material_in;
                        work_d     = '0;
                        step_d     = '0;
                        state_d    = S_CLEAR;
                    end
                end
                S_CLEAR: state_d = S_RUN;
                S_RUN: begin
                    count_en = 1'b1;
                    if (step_q == STEP_W'(T_STEPS - 1)) begin
                        step_d = '0;
                        if (SETTLE == 0) begin
                            state_d      = S_DONE;
                            load_results = 1'b1;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    count_en = 1'b1;
                    if (step_q == STEP_W'(SETTLE - 1)) begin
                        step_d       = '0;
                        state_d      = S_DONE;
                        load_results = 1'b1;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Saturating counters: a counter that is all ones stays all ones.
        if (count_en) begin
            for (int i = 0; i < EXCNUM; i++) begin
                if (bus.spike_in[i] && work_q[i] != '1) begin
                    work_d[i] = work_q[i] + 1'b1;
                end
            end
        end

        // The results load on the edge into DONE. They use the post-increment
        // counts, so a spike in the last RUN or DRAIN cycle still counts.
        if (load_results) begin
            count_l_d = work_d[0];
            count_r_d = work_d[1];
            winner_d  = decide(work_d[0], work_d[1]);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register update from the
        // same values, the ones present before the edge.
        if (rst) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            work_q     <= '0;
            count_l_q  <= '0;
            count_r_q  <= '0;
            winner_q   <= 2'b00;
            sensor_q   <= 4'b0000;
            material_q <= 4'b0000;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            work_q     <= work_d;
            count_l_q  <= count_l_d;
            count_r_q  <= count_r_d;
            winner_q   <= winner_d;
            sensor_q   <= sensor_d;
            material_q <= material_d;
        end
    end

    // The network reset follows rst directly, so it is asserted even before
    // the first clock edge.
    assign bus.snn_rst      = rst | (state_q == S_CLEAR);
    assign bus.snn_en       = bus.en & (state_q == S_RUN);
    assign bus.snn_sensor   = sensor_q;
    assign bus.snn_material = material_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.count_l      = count_l_q;
    assign bus.count_r      = count_r_q;
    assign bus.winner       = winner_q;
endmodule

// File: tb/tb_snn_inference_sequencer.sv
// -----------------------------------------------------------------------------
// tb_snn_inference_sequencer
// Two sequencers share one set of stimulus:
//   dut_a uses the default CNT_W = 5.
//   dut_b uses CNT_W = 4, so its counters saturate within a window.
// The reference model tracks each window by its age in enabled cycles:
//   age 1                  network reset
//   age 2 .. T+1           network enabled
//   age up to T+1+SETTLE   spikes still counted
//   age T+SETTLE+2         done
// It counts spikes without limit and clips them only when forming each
// DUT's expected result.
// -----------------------------------------------------------------------------
module tb_snn_inference_sequencer;
    localparam int T  = 16;
    localparam int S  = 2;
    localparam int WA = 5;
    localparam int WB = 4;

    typedef enum int {P_BASIC, P_DRAIN, P_TIE, P_NONE, P_SAT, P_RAND} pat_e;

    logic       clk = 1'b0;
    logic       rst, en, start;
    logic [3:0] sensor, material;
    logic [1:0] spike;

    int n_pass  = 0;
    int n_total = 0;
    int done_seen;

    // Reference model state.
    bit         m_active;
    int         m_age;
    int         m_wl, m_wr, m_res_l, m_res_r;
    logic [3:0] m_sen, m_mat;

    always #5 clk = ~clk;

    snn_inference_sequencer_if #(.EXCNUM(2), .CNT_W(WA)) bus_a ();
    snn_inference_sequencer_if #(.EXCNUM(2), .CNT_W(WB)) bus_b ();

    assign bus_a.en          = en;
    assign bus_a.start       = start;
    assign bus_a.sensor_in   = sensor;
    assign bus_a.material_in = material;
    assign bus_a.spike_in    = spike;
    assign bus_b.en          = en;
    assign bus_b.start       = start;
    assign bus_b.sensor_in   = sensor;
    assign bus_b.material_in = material;
    assign bus_b.spike_in    = spike;

    snn_inference_sequencer #(.EXCNUM(2), .T_STEPS(T), .SETTLE(S), .CNT_W(WA)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    snn_inference_sequencer #(.EXCNUM(2), .T_STEPS(T), .SETTLE(S), .CNT_W(WB)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int sat(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    function automatic logic [1:0] win(input int l, input int r);
        if (l == 0 && r == 0) return 2'b00;
        if (l == r)           return 2'b11;
        return (l > r) ? 2'b01 : 2'b10;
    endfunction

    // Advances the model by one clock edge, using the inputs the DUTs sampled.
    task automatic model_update();
        if (rst) begin
            m_active = 0; m_age = 0; m_wl = 0; m_wr = 0;
            m_res_l = 0; m_res_r = 0; m_sen = 4'h0; m_mat = 4'h0;
        end else if (en) begin
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_age = 1; m_wl = 0; m_wr = 0;
                    m_sen = sensor; m_mat = material;
                end
            end else begin
                if (m_age >= 2 && m_age <= T + 1 + S) begin
                    m_wl += int'(spike[0]);
                    m_wr += int'(spike[1]);
                end
                if (m_age == T + S + 1) begin
                    m_res_l = m_wl;
                    m_res_r = m_wr;
                end
                if (m_age == T + S + 2) m_active = 0;
                else m_age++;
            end
        end
    endtask

    task automatic check_all();
        logic e_rst, e_en, e_done;
        e_rst  = rst || (m_active && m_age == 1);
        e_en   = m_active && en && m_age >= 2 && m_age <= T + 1;
        e_done = m_active && m_age == T + S + 2;
        if (bus_a.done === 1'b1) done_seen++;
        check("a.snn_rst", 32'(bus_a.snn_rst), 32'(e_rst));
        check("a.snn_en", 32'(bus_a.snn_en), 32'(e_en));
        check("a.busy", 32'(bus_a.busy), 32'(m_active));
        check("a.done", 32'(bus_a.done), 32'(e_done));
        check("a.snn_sensor", 32'(bus_a.snn_sensor), 32'(m_sen));
        check("a.snn_material", 32'(bus_a.snn_material), 32'(m_mat));
        check("a.count_l", 32'(bus_a.count_l), sat(m_res_l, WA));
        check("a.count_r", 32'(bus_a.count_r), sat(m_res_r, WA));
        check("a.winner", 32'(bus_a.winner), 32'(win(sat(m_res_l, WA), sat(m_res_r, WA))));
        check("b.snn_en", 32'(bus_b.snn_en), 32'(e_en));
        check("b.done", 32'(bus_b.done), 32'(e_done));
        check("b.count_l", 32'(bus_b.count_l), sat(m_res_l, WB));
        check("b.count_r", 32'(bus_b.count_r), sat(m_res_r, WB));
        check("b.winner", 32'(bus_b.winner), 32'(win(sat(m_res_l, WB), sat(m_res_r, WB))));
    endtask

    // One clock: the edge is applied to the model, and outputs are sampled at
    // the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic cycle(input logic s, input logic [1:0] sp);
        start    = s;
        spike    = sp;
        sensor   = 4'($urandom);
        material = 4'($urandom);
        tick();
    endtask

    task automatic start_cycle(input logic [3:0] sen, input logic [3:0] mat, input logic [1:0] sp);
        start    = 1'b1;
        spike    = sp;
        sensor   = sen;
        material = mat;
        tick();
        start    = 1'b0;
    endtask

    // k is the cycle offset from the accepted start (k = 0).
    function automatic logic [1:0] spike_pat(input pat_e p, input int k);
        case (p)
            P_BASIC: return {(k == 4 || k == 10),
                             (k == 3 || k == 5 || k == 7 || k == 9 || k == 11)};
            P_DRAIN: return {(k >= 17 && k <= 20), 1'b0};
            P_TIE:   return (k >= 2 && k <= 5) ? 2'b11 : 2'b00;
            P_SAT:   return 2'b11;
            P_RAND:  return 2'($urandom);
            default: return 2'b00;
        endcase
    endfunction

    // Runs from the start cycle up to the point where the done cycle
    // (k = T+S+2) is being observed.
    task automatic window(input pat_e p, input logic [3:0] sen, input logic [3:0] mat);
        start_cycle(sen, mat, spike_pat(p, 0));
        for (int k = 1; k <= T + S + 1; k++) cycle(1'b0, spike_pat(p, k));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; spike = 2'b00;
        sensor = 4'h0; material = 4'h0;
        m_active = 0; m_age = 0; m_wl = 0; m_wr = 0;
        m_res_l = 0; m_res_r = 0; m_sen = 4'h0; m_mat = 4'h0;
        done_seen = 0;

        // Reset for 3 cycles, then release.
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b11);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b0, 2'b11);
        check("reset.snn_rst", 32'(bus_a.snn_rst), 0);
        check("reset.busy", 32'(bus_a.busy), 0);

        // Basic window: 5 Left spikes and 2 Right spikes during RUN.
        window(P_BASIC, 4'b1100, 4'b0011);
        check("basic.done", 32'(bus_a.done), 1);
        check("basic.count_l", 32'(bus_a.count_l), 5);
        check("basic.count_r", 32'(bus_a.count_r), 2);
        check("basic.winner", 32'(bus_a.winner), 32'h1);
        check("basic.sensor", 32'(bus_a.snn_sensor), 32'hc);
        cycle(1'b0, 2'b00);

        // Drain edges: spikes in the last RUN cycle and both DRAIN cycles
        // count; the spike in the DONE cycle does not.
        window(P_DRAIN, 4'h5, 4'ha);
        check("drain.count_r", 32'(bus_a.count_r), 3);
        check("drain.winner", 32'(bus_a.winner), 32'h2);
        cycle(1'b0, spike_pat(P_DRAIN, T + S + 2));
        check("drain.hold_r", 32'(bus_a.count_r), 3);

        window(P_TIE, 4'h1, 4'h2);
        check("tie.winner", 32'(bus_a.winner), 32'h3);
        cycle(1'b0, 2'b00);
        window(P_NONE, 4'h3, 4'h4);
        check("none.winner", 32'(bus_a.winner), 32'h0);
        cycle(1'b0, 2'b00);

        // Saturation: both spike lines held high for the whole window.
        window(P_SAT, 4'hf, 4'hf);
        check("sat.b_count_l", 32'(bus_b.count_l), 15);
        check("sat.b_count_r", 32'(bus_b.count_r), 15);
        check("sat.b_winner", 32'(bus_b.winner), 32'h3);
        check("sat.a_count_l", 32'(bus_a.count_l), 18);
        cycle(1'b0, 2'b00);

        // A second start while busy is ignored. A 5-cycle en stall while
        // spikes are driven delays done by 5 cycles and adds no counts.
        done_seen = 0;
        start_cycle(4'h9, 4'h6, 2'b00);
        for (int k = 1; k <= 7; k++) cycle(k == 5, (k == 3) ? 2'b01 : 2'b00);
        en = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'b11);
        en = 1'b1;
        for (int j = 0; j < 11; j++) cycle(1'b0, (j < 2) ? 2'b01 : 2'b00);
        check("stall.not_yet", 32'(bus_a.done), 0);
        cycle(1'b0, 2'b00);
        check("stall.done", 32'(bus_a.done), 1);
        check("stall.count_l", 32'(bus_a.count_l), 3);
        check("stall.count_r", 32'(bus_a.count_r), 0);
        check("stall.sensor", 32'(bus_a.snn_sensor), 32'h9);
        cycle(1'b0, 2'b00);
        check("stall.one_done", done_seen, 1);

        // rst at RUN step 7 returns to IDLE, clears results, issues no done.
        done_seen = 0;
        start_cycle(4'h7, 4'h8, 2'b00);
        for (int k = 1; k <= 8; k++) cycle(1'b0, 2'b11);
        rst = 1'b1;
        cycle(1'b0, 2'b11);
        check("rst.busy", 32'(bus_a.busy), 0);
        check("rst.count_l", 32'(bus_a.count_l), 0);
        check("rst.winner", 32'(bus_a.winner), 0);
        rst = 1'b0;
        cycle(1'b0, 2'b00);
        cycle(1'b0, 2'b00);
        check("rst.no_done", done_seen, 0);
        window(P_RAND, 4'h2, 4'hd);
        check("rst.restart_done", 32'(bus_a.done), 1);
        cycle(1'b0, 2'b00);

        // start held high yields one window every T+S+3 cycles.
        done_seen = 0;
        for (int i = 0; i < 3 * (T + S + 3); i++) cycle(1'b1, 2'($urandom));
        check("b2b.done_count", done_seen, 3);
        cycle(1'b0, 2'b00);

        // Random traffic: start, en, spikes and occasional rst.
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 149) == 0);
            cycle($urandom_range(0, 3) == 0, 2'($urandom));
        end
        en = 1'b1; rst = 1'b0;
        for (int i = 0; i < T + S + 5; i++) cycle(1'b0, 2'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
